barcode_rx: RTL and testbench

//  Decodes the serial barcode stripe signal BC seen by the floor sensor into an 8-bit station ID.
//  A measured start pulse sets the bit period for the rest of the frame.

---
 rtl/bc_pkg.sv | 22 ++
 rtl/bc_sync.sv | 35 +++
 rtl/barcode_rx.sv | 138 +++++++++++++
 tb/tb_barcode_rx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg : shared types and constants for the barcode station-ID receiver
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_FALL = 3'd2,
        SAMPLE    = 3'd3,
        DONE      = 3'd4
    } bc_state_t;

    localparam int         BC_TMR_W  = 22;
    localparam logic [1:0] BC_ID_TAG = 2'b00;

endpackage

`default_nettype wire

// File: rtl/bc_sync.sv
// ---------------------------------------------------------------------------
// bc_sync : 3-flop synchroniser for the barcode sensor with edge detect
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bc_sync
    import bc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic bc_s,
    output logic bc_fall,
    output logic bc_rise
);

    // Preset high so leaving reset with the line idle never looks like an edge
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], bc};
        end
    end

    assign bc_s    = sync_q[1];
    assign bc_fall =  sync_q[2] & ~sync_q[1];
    assign bc_rise = ~sync_q[2] &  sync_q[1];

endmodule

`default_nettype wire

// File: rtl/barcode_rx.sv
// ---------------------------------------------------------------------------
// barcode_rx : decodes the floor barcode stripe into a sticky 8-bit station ID
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module barcode_rx
    import bc_pkg::*;
#(
    parameter int TMR_W    = BC_TMR_W,
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                BC,
    input  logic                clr_ID_vld,
    output logic [NUM_BITS-1:0] ID,
    output logic                ID_vld
);

    localparam int CNT_W = $clog2(NUM_BITS);

    logic bc_s, bc_fall, bc_rise;

    bc_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .bc      (BC),
        .bc_s    (bc_s),
        .bc_fall (bc_fall),
        .bc_rise (bc_rise)
    );

    bc_state_t           state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [TMR_W-1:0]    period_q, period_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [NUM_BITS-1:0] id_q, id_d;
    logic                id_vld_q, id_vld_d;

    logic tmr_full, tmr_hit, last_bit;
    assign tmr_full = &timer_q;
    assign tmr_hit  = (timer_q == period_q);
    assign last_bit = (bitcnt_q == CNT_W'(NUM_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bc_fall) state_d = START;
            START: begin
                if (tmr_full)     state_d = IDLE;
                else if (bc_rise) state_d = WAIT_FALL;
            end
            WAIT_FALL: if (bc_fall) state_d = SAMPLE;
            SAMPLE:    if (tmr_hit) state_d = last_bit ? DONE : WAIT_FALL;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The edge cycle is counted as 1, so the period equals the synced low length
    // and each bit is sampled exactly one period after its falling edge.
    always_comb begin
        timer_d  = timer_q;
        period_d = period_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        id_d     = id_q;
        id_vld_d = clr_ID_vld ? 1'b0 : id_vld_q;
        case (state_q)
            IDLE: begin
                timer_d  = bc_fall ? TMR_W'(1) : '0;
                bitcnt_d = '0;
            end
            START: begin
                if (tmr_full) begin
                    timer_d = '0;
                end else if (bc_rise) begin
                    period_d = timer_q;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_FALL: begin
                if (bc_fall) timer_d = TMR_W'(1);
            end
            SAMPLE: begin
                if (tmr_hit) begin
                    shreg_d  = {shreg_q[NUM_BITS-2:0], bc_s};
                    bitcnt_d = last_bit ? '0 : bitcnt_q + CNT_W'(1);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                timer_d = '0;
                if (shreg_q[NUM_BITS-1 -: 2] == BC_ID_TAG) begin
                    id_d     = shreg_q;
                    id_vld_d = 1'b1;
                end
            end
            default: timer_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q  <= '0;
            period_q <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            id_q     <= '0;
            id_vld_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            period_q <= period_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            id_q     <= id_d;
            id_vld_q <= id_vld_d;
        end
    end

    assign ID     = id_q;
    assign ID_vld = id_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_barcode_rx.sv
// ---------------------------------------------------------------------------
// tb_barcode_rx : scoreboard bench for barcode_rx (timer narrowed to 10 bits)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_barcode_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BC = 1'b1;
    logic       clr_ID_vld = 1'b0;
    logic [7:0] ID;
    logic       ID_vld;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [7:0] id;
        logic       vld;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_id  = 8'h00;
    logic       m_vld = 1'b0;

    barcode_rx #(.TMR_W(10), .NUM_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends start pulse plus nbits data bits MSB first; a full frame pushes its
    // expected outcome. Observations around the last sample are returned.
    task automatic send_frame(input logic [7:0] id, input int p, input int nbits,
                              input bit clr_in_done,
                              output logic vld_p3, output logic vld_p4,
                              output int vld_drops);
        int low;
        logic [7:0] bits;
        bits      = id;
        vld_p3    = 1'bx;
        vld_p4    = 1'bx;
        vld_drops = 0;
        BC = 1'b0;
        cyc(p);
        BC = 1'b1;
        cyc(p);
        for (int n = 0; n < nbits; n++) begin
            low = bits[7-n] ? p / 2 : (3 * p) / 2;
            BC = 1'b0;
            for (int i = 1; i <= 2 * p; i++) begin
                cyc(1);
                if (i == low) BC = 1'b1;
                if (ID_vld !== 1'b1) vld_drops++;
                if (n == 7 && i == p + 3) begin
                    vld_p3 = ID_vld;
                    if (clr_in_done) clr_ID_vld = 1'b1;
                end
                if (n == 7 && i == p + 4) begin
                    vld_p4 = ID_vld;
                    clr_ID_vld = 1'b0;
                end
            end
        end
        if (nbits == 8) begin
            if (id[7:6] == 2'b00) begin
                m_id  = id;
                m_vld = 1'b1;
            end
            exp_q.push_back('{id: m_id, vld: m_vld});
        end
        cyc(20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        n_vec++;
        if (ID !== 8'h00 || ID_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL reset: ID=%h ID_vld=%b, required ID=00 ID_vld=0", ID, ID_vld);
        end
        rst_n = 1'b1;
        cyc(10);
        n_vec++;
        if (ID_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_release: ID_vld=%b, required 0", ID_vld);
        end
    endtask

    task automatic test_basic();
        logic v3, v4;
        int   d;
        exp_t e;
        send_frame(8'h25, 1000, 8, 1'b0, v3, v4, d);
        n_vec++;
        if (v3 !== 1'b0 || v4 !== 1'b1) begin
            n_miss++;
            $display("FAIL latency: vld@+3=%b vld@+4=%b, required 0 then 1", v3, v4);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL basic_25: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
    endtask

    task automatic test_clear();
        clr_ID_vld = 1'b1;
        cyc(1);
        clr_ID_vld = 1'b0;
        m_vld = 1'b0;
        n_vec++;
        if (ID_vld !== 1'b0 || ID !== 8'h25) begin
            n_miss++;
            $display("FAIL clear: ID=%h vld=%b, required ID=25 vld=0", ID, ID_vld);
        end
        clr_ID_vld = 1'b1;
        cyc(2);
        clr_ID_vld = 1'b0;
        n_vec++;
        if (ID_vld !== 1'b0 || ID !== 8'h25) begin
            n_miss++;
            $display("FAIL clear_idle: ID=%h vld=%b, required ID=25 vld=0", ID, ID_vld);
        end
    endtask

    task automatic test_bad_tag();
        logic v3, v4;
        int   d;
        exp_t e;
        send_frame(8'hC5, 200, 8, 1'b0, v3, v4, d);
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL bad_tag_C5: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
        send_frame(8'h12, 200, 8, 1'b0, v3, v4, d);
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL after_bad_12: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
    endtask

    task automatic test_back_to_back();
        logic v3, v4;
        int   d;
        exp_t e;
        send_frame(8'h3F, 200, 8, 1'b0, v3, v4, d);
        n_vec++;
        if (d != 0) begin
            n_miss++;
            $display("FAIL overwrite_hold: ID_vld low for %0d cycles, required 0", d);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL overwrite_3F: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
        send_frame(8'h2A, 200, 8, 1'b1, v3, v4, d);
        n_vec++;
        if (v4 !== 1'b1 || d != 0) begin
            n_miss++;
            $display("FAIL set_wins: vld after DONE=%b low_cycles=%0d, required 1 and 0", v4, d);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL set_wins_2A: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
    endtask

    task automatic test_mid_reset();
        logic v3, v4;
        int   d;
        int   spur;
        exp_t e;
        send_frame(8'h0A, 200, 4, 1'b0, v3, v4, d);
        rst_n = 1'b0;
        #1;
        m_id  = 8'h00;
        m_vld = 1'b0;
        n_vec++;
        if (ID !== 8'h00 || ID_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset: ID=%h vld=%b, required ID=00 vld=0", ID, ID_vld);
        end
        cyc(3);
        rst_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (ID_vld !== 1'b0) spur++;
        end
        n_vec++;
        if (spur != 0) begin
            n_miss++;
            $display("FAIL reset_release_vld: vld high %0d cycles, required 0", spur);
        end
        send_frame(8'h0A, 200, 8, 1'b0, v3, v4, d);
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL after_reset_0A: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
    endtask

    task automatic test_abort();
        logic v3, v4;
        int   d;
        int   spur;
        exp_t e;
        clr_ID_vld = 1'b1;
        cyc(1);
        clr_ID_vld = 1'b0;
        m_vld = 1'b0;
        BC = 1'b0;
        spur = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc(1);
            if (ID_vld !== 1'b0) spur++;
        end
        BC = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (ID_vld !== 1'b0) spur++;
        end
        n_vec++;
        if (spur != 0 || ID !== 8'h0A) begin
            n_miss++;
            $display("FAIL abort: vld high %0d cycles ID=%h, required 0 cycles ID=0A", spur, ID);
        end
        send_frame(8'h01, 200, 8, 1'b0, v3, v4, d);
        e = exp_q.pop_front();
        n_vec++;
        if (ID !== e.id || ID_vld !== e.vld) begin
            n_miss++;
            $display("FAIL after_abort_01: ID=%h vld=%b, required ID=%h vld=%b", ID, ID_vld, e.id, e.vld);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_bad_tag();
        test_back_to_back();
        test_mid_reset();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
